noc_input_port: RTL and testbench



---
 rtl/noc_pkg.sv | 27 ++
 rtl/noc_input_port_if.sv | 27 ++
 rtl/noc_flit_fifo.sv | 49 ++++
 rtl/noc_input_port.sv | 73 +++++++
 tb/tb_noc_input_port.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit layout, port count and route state encoding
package noc_pkg;

  localparam int FLIT_W    = 13;
  localparam int NUM_PORTS = 4;

  localparam int DEST_MSB = 12;
  localparam int DEST_LSB = 11;
  localparam int TYPE_MSB = 10;
  localparam int TYPE_LSB = 9;
  localparam int PAY_MSB  = 8;
  localparam int PAY_LSB  = 1;
  localparam int EOP_BIT  = 0;

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] ptype;
    logic [7:0] payload;
    logic       eop;
  } flit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } port_state_e;

endpackage

// File: rtl/noc_input_port_if.sv
// rtl/noc_input_port_if.sv - upstream flit handshake plus four-way output bundle
interface noc_input_port_if #(
  parameter int CNT_W = 16
);
  import noc_pkg::*;

  logic                  valid_in;
  logic [FLIT_W-1:0]     packet_in;
  logic                  ready_out;
  logic [NUM_PORTS-1:0]  out_valid;
  logic [FLIT_W-1:0]     out_flit;
  logic [NUM_PORTS-1:0]  out_ready;
  logic                  route_busy;
  logic                  pkt_done;
  logic [CNT_W-1:0]      pkt_count;

  modport master (
    output valid_in, packet_in, out_ready,
    input  ready_out, out_valid, out_flit, route_busy, pkt_done, pkt_count
  );

  modport slave (
    input  valid_in, packet_in, out_ready,
    output ready_out, out_valid, out_flit, route_busy, pkt_done, pkt_count
  );

endinterface

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - small flit FIFO with registered count and head-of-line output
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [FLIT_W-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the shared output bus reads zero until new data lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - router input port: flit buffer, wormhole route lock, packet counter
module noc_input_port
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  noc_input_port_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_FWD  = FWD;

  logic [0:0]       r_state;
  logic [1:0]       r_route;
  logic [CNT_W-1:0] r_pkt_count;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_eop_pop;
  logic [FLIT_W-1:0] w_head_bits;
  flit_t             w_head;

  noc_flit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.packet_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head_bits)
  );

  assign w_head = flit_t'(w_head_bits);

  // No bypass: a full FIFO refuses a flit even if the head leaves this cycle.
  assign w_ready   = !w_full && !reset;
  assign w_push    = bus.valid_in && w_ready;
  assign w_pop     = (r_state == ST_FWD) && !w_empty && bus.out_ready[r_route];
  assign w_eop_pop = w_pop && w_head.eop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_route     <= '0;
      r_pkt_count <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!w_empty) begin
        r_route <= w_head.dest;
        r_state <= ST_FWD;
      end
    end else if (w_eop_pop) begin
      r_state     <= ST_IDLE;
      r_pkt_count <= r_pkt_count + 1'b1;
    end
  end

  assign bus.ready_out  = w_ready;
  assign bus.out_valid  = ((r_state == ST_FWD) && !w_empty) ? (4'b0001 << r_route) : 4'b0000;
  assign bus.out_flit   = w_head;
  assign bus.route_busy = (r_state == ST_FWD);
  assign bus.pkt_done   = w_eop_pop;
  assign bus.pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_noc_input_port.sv
// tb/tb_noc_input_port.sv - directed and randomized bench with a queue-based packet model
module tb_noc_input_port;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  noc_input_port_if #(.CNT_W(CNT_W)) bus_if ();

  noc_input_port #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int failures = 0;

  logic [12:0] tx_q[$];
  logic [12:0] model_q[$];
  bit          m_locked = 0;
  int          m_route = 0;
  int          m_count = 0;

  function automatic logic [12:0] mk(input int d, input int t, input int p, input int e);
    logic [1:0] dd;
    logic [1:0] tt;
    logic [7:0] pp;
    logic       ee;
    dd = 2'(d);
    tt = 2'(t);
    pp = 8'(p);
    ee = 1'(e);
    return {dd, tt, pp, ee};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pick_rdy(input int mode);
    if (mode == 0) return 4'hF;
    if (mode == 1) return 4'h0;
    return 4'($urandom_range(15));
  endfunction

  // One clock: drive at the falling edge, check 1 ns later, update the model at the rising edge.
  task automatic tick(input logic [3:0] rdy, input int gap_pct);
    logic       v;
    logic [3:0] ev;
    logic [12:0] hd;
    bit         push;
    bit         pop;
    bit         eop_pop;
    v = (tx_q.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
    bus_if.valid_in  = v;
    bus_if.packet_in = v ? tx_q[0] : 13'($urandom);
    bus_if.out_ready = rdy;
    #1;
    ev = (m_locked && model_q.size() > 0) ? 4'(1 << m_route) : 4'h0;
    pop = (ev != 4'h0) && rdy[m_route];
    eop_pop = pop && model_q[0][0];
    push = v && (model_q.size() < DEPTH);
    chk("out_valid", 32'(bus_if.out_valid), 32'(ev));
    chk("ready_out", 32'(bus_if.ready_out), 32'(model_q.size() < DEPTH));
    chk("route_busy", 32'(bus_if.route_busy), 32'(m_locked));
    chk("pkt_done", 32'(bus_if.pkt_done), 32'(eop_pop));
    chk("pkt_count", 32'(bus_if.pkt_count), 32'(m_count));
    if (ev != 4'h0) chk("out_flit", 32'(bus_if.out_flit), 32'(model_q[0]));
    @(posedge clk);
    if (!m_locked && model_q.size() > 0) begin
      m_locked = 1;
      m_route = int'(model_q[0][12:11]);
    end else if (pop) begin
      hd = model_q.pop_front();
      if (hd[0]) begin
        m_locked = 0;
        m_count = (m_count + 1) % CNT_MOD;
      end
    end
    if (push) model_q.push_back(tx_q.pop_front());
    @(negedge clk);
  endtask

  task automatic drain(input int rdy_mode, input int gap_pct, input int max_cycles);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || model_q.size() > 0 || m_locked) && n < max_cycles) begin
      tick(pick_rdy(rdy_mode), gap_pct);
      n++;
    end
    chk("drain_timeout", 32'(tx_q.size() + model_q.size() + int'(m_locked)), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    bus_if.valid_in  = 1'b0;
    bus_if.packet_in = '0;
    bus_if.out_ready = 4'h0;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus_if.ready_out), 32'd0);
    chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_flit", 32'(bus_if.out_flit), 32'd0);
    chk("rst_busy", 32'(bus_if.route_busy), 32'd0);
    chk("rst_done", 32'(bus_if.pkt_done), 32'd0);
    chk("rst_count", 32'(bus_if.pkt_count), 32'd0);
    reset = 1'b0;
    tx_q.delete();
    model_q.delete();
    m_locked = 0;
    m_count = 0;
  endtask

  initial begin
    int len;
    int d;
    bus_if.valid_in  = 1'b0;
    bus_if.packet_in = '0;
    bus_if.out_ready = 4'h0;
    do_reset(2);

    // Single-flit packet to port 2.
    tx_q.push_back(mk(2, 0, 'hAA, 1));
    drain(0, 0, 50);
    chk("single_count", 32'(bus_if.pkt_count), 32'd1);
    chk("single_busy", 32'(bus_if.route_busy), 32'd0);

    // Three-flit wormhole packet; body/tail dest fields must be ignored.
    tx_q.push_back(mk(1, 1, 'h11, 0));
    tx_q.push_back(mk(3, 2, 'h22, 0));
    tx_q.push_back(mk(0, 3, 'h33, 1));
    drain(0, 0, 50);
    chk("worm_count", 32'(bus_if.pkt_count), 32'd2);

    // Backpressure: five offered flits against a stalled output.
    d = int'($urandom_range(3));
    for (int i = 0; i < 5; i++) tx_q.push_back(mk(i == 0 ? d : 3 - d, i, 'h40 + i, i == 4 ? 1 : 0));
    repeat (8) tick(4'h0, 0);
    chk("bp_full_ready", 32'(bus_if.ready_out), 32'd0);
    chk("bp_held", 32'(tx_q.size()), 32'd1);
    drain(0, 0, 50);
    chk("bp_count", 32'(bus_if.pkt_count), 32'd3);

    // Streaming: five four-flit packets, destinations rotating.
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 4; i++) tx_q.push_back(mk(i == 0 ? p % 4 : int'($urandom_range(3)), 0, p * 16 + i, i == 3 ? 1 : 0));
    drain(0, 0, 100);
    chk("stream_count", 32'(bus_if.pkt_count), 32'd8);

    // Reset in the middle of a packet, then a fresh header to port 0.
    tx_q.push_back(mk(3, 0, 'h5A, 0));
    tx_q.push_back(mk(1, 0, 'h5B, 0));
    tx_q.push_back(mk(2, 0, 'h5C, 1));
    tick(4'h0, 0);
    tick(4'h0, 0);
    do_reset(1);
    tx_q.push_back(mk(0, 1, 'h77, 1));
    tick(4'hF, 0);
    tick(4'hF, 0);
    chk("after_rst_valid", 32'(bus_if.out_valid), 32'b0001);
    drain(0, 0, 50);
    chk("after_rst_count", 32'(bus_if.pkt_count), 32'd1);

    // Counter wrap with a 4-bit counter.
    do_reset(1);
    for (int i = 0; i < 17; i++) tx_q.push_back(mk(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(255)), 1));
    drain(0, 0, 200);
    chk("wrap_count", 32'(bus_if.pkt_count), 32'd1);

    // Randomized packets, source gaps and per-port readiness.
    for (int p = 0; p < 40; p++) begin
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++)
        tx_q.push_back(mk(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(255)), i == len - 1 ? 1 : 0));
    end
    drain(2, 30, 8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
